// File: rtl/mem_responder.sv
// mem_responder: word-array memory slave with a ready (R) handshake and
// a programmable number of wait states per access.
//
// Parameters:
//   DEPTH_LOG2  - array holds 2**DEPTH_LOG2 16-bit words
//   WAIT_CYCLES - wait states inserted per access (0..15)
//
// Ports:
//   Clk     - clock, all state updates on the rising edge
//   Reset   - synchronous, active-low reset (array contents are kept)
//   ADDR    - 20-bit word address
//   Data    - 16-bit shared tri-state bus (driven only when acknowledging a read)
//   MEM_RD  - read request, held until R is seen
//   MEM_WR  - write request, held until R is seen
//   MEM_UB  - upper byte enable (only with MEM_BYTE_WE_EN)
//   MEM_LB  - lower byte enable (only with MEM_BYTE_WE_EN)
//   R       - ready/acknowledge
//
// Compile-time option: MEM_BYTE_WE_EN adds the MEM_UB/MEM_LB byte-write
// enables; without it every write updates the full word.
//
// state | meaning
// IDLE  | waiting for exactly one of MEM_RD/MEM_WR
// WAIT  | request captured, counting wait states
// ACK   | R high; read data on the bus; wait for the request to drop

module mem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [19:0] ADDR,
    inout  wire  [15:0] Data,
    input  logic        MEM_RD,
    input  logic        MEM_WR,
`ifdef MEM_BYTE_WE_EN
    input  logic        MEM_UB,
    input  logic        MEM_LB,
`endif
    output logic        R
);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam int         WORDS     = 1 << DEPTH_LOG2;

    logic [15:0] mem [WORDS];

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    op_rd_q, op_rd_d;
    logic                    op_wr_q, op_wr_d;
    logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
    logic                    inr_q, inr_d;
    logic [15:0]             wdata_q, wdata_d;
    logic [1:0]              be_q, be_d;

    logic                    req_one;
    logic                    req_held;
    logic                    addr_inr;
    logic [1:0]              in_be;

    logic                    mem_we;
    logic [DEPTH_LOG2-1:0]   we_addr;
    logic [15:0]             we_data;
    logic [1:0]              we_be;
    logic                    we_inr;

    logic [15:0]             rdata;

`ifdef MEM_BYTE_WE_EN
    assign in_be = {MEM_UB, MEM_LB};
`else
    assign in_be = 2'b11;
`endif

    assign req_one  = MEM_RD ^ MEM_WR;
    assign req_held = op_wr_q ? MEM_WR : MEM_RD;
    assign addr_inr = (ADDR >> DEPTH_LOG2) == 20'd0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_rd_d = op_rd_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        inr_d   = inr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        mem_we  = 1'b0;
        we_addr = addr_q;
        we_data = wdata_q;
        we_be   = be_q;
        we_inr  = inr_q;

        unique case (state_q)
            IDLE: begin
                if (req_one) begin
                    op_rd_d = MEM_RD;
                    op_wr_d = MEM_WR;
                    addr_d  = ADDR[DEPTH_LOG2-1:0];
                    inr_d   = addr_inr;
                    cnt_d   = WAIT_INIT;
                    if (MEM_WR) begin
                        wdata_d = Data;
                        be_d    = in_be;
                    end
                    if (WAIT_INIT == 4'd0) begin
                        // Zero wait states: ACK is entered on the capture edge,
                        // so the write has to use the live bus values.
                        state_d = ACK;
                        mem_we  = MEM_WR;
                        we_addr = ADDR[DEPTH_LOG2-1:0];
                        we_data = Data;
                        we_be   = in_be;
                        we_inr  = addr_inr;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req_held) begin
                    // Abort wins even on the edge that would have entered ACK.
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = ACK;
                        mem_we  = op_wr_q;
                    end
                end
            end
            ACK: begin
                if (!req_held) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_rd_q <= 1'b0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            inr_q   <= 1'b0;
            wdata_q <= 16'h0000;
            be_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_rd_q <= op_rd_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            inr_q   <= inr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    // Array is never reset; a reset on the ACK-entry edge suppresses the write.
    always_ff @(posedge Clk) begin
        if (Reset && mem_we && we_inr) begin
            if (we_be[1]) mem[we_addr][15:8] <= we_data[15:8];
            if (we_be[0]) mem[we_addr][7:0]  <= we_data[7:0];
        end
    end

    assign rdata = inr_q ? mem[addr_q] : 16'h0000;
    assign R     = (state_q == ACK);
    assign Data  = (state_q == ACK && op_rd_q) ? rdata : 16'bz;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int W1 = 2;
    localparam int W0 = 0;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;

    logic [19:0] addr1 = '0, addr0 = '0;
    logic        rd1 = 0, wr1 = 0, rd0 = 0, wr0 = 0;
    logic        oe1 = 1, oe0 = 1;
    logic [15:0] drv1 = '0, drv0 = '0;
    logic        ub1 = 1, lb1 = 1, ub0 = 1, lb0 = 1;
    logic        R1, R0;
    wire  [15:0] Data1, Data0;

    assign Data1 = oe1 ? drv1 : 16'bz;
    assign Data0 = oe0 ? drv0 : 16'bz;

    int checks = 0;
    int errors = 0;

    logic [15:0] mdl [int];

    always #5 Clk = ~Clk;

    mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(W1)) dut (
        .Clk(Clk), .Reset(Reset), .ADDR(addr1), .Data(Data1),
        .MEM_RD(rd1), .MEM_WR(wr1),
`ifdef MEM_BYTE_WE_EN
        .MEM_UB(ub1), .MEM_LB(lb1),
`endif
        .R(R1)
    );

    mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(W0)) dut0 (
        .Clk(Clk), .Reset(Reset), .ADDR(addr0), .Data(Data0),
        .MEM_RD(rd0), .MEM_WR(wr0),
`ifdef MEM_BYTE_WE_EN
        .MEM_UB(ub0), .MEM_LB(lb0),
`endif
        .R(R0)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic get_r(input bit u0);
        return u0 ? R0 : R1;
    endfunction

    function automatic logic [15:0] get_d(input bit u0);
        return u0 ? Data0 : Data1;
    endfunction

    task automatic drive(input bit u0, input bit rd, input bit wr, input logic [19:0] a,
                         input logic [15:0] d, input bit oe, input bit ub, input bit lb);
        if (u0) begin
            rd0 = rd; wr0 = wr; addr0 = a; drv0 = d; oe0 = oe; ub0 = ub; lb0 = lb;
        end else begin
            rd1 = rd; wr1 = wr; addr1 = a; drv1 = d; oe1 = oe; ub1 = ub; lb1 = lb;
        end
    endtask

    // One full handshake. abort_after >= 0 drops the request that many edges
    // after the capture edge (while still waiting).
    task automatic txn(input bit u0, input bit wr, input logic [19:0] a, input logic [15:0] d,
                       input bit ub, input bit lb, input int abort_after,
                       output logic [15:0] rd);
        int lat;
        int lat_exp;
        bit got;
        logic [15:0] base;
        lat_exp = (u0 ? W0 : W1) + 1;
        rd = 16'h0000;
        @(posedge Clk); #1;
        drive(u0, !wr, wr, a, d, wr, ub, lb);
        @(posedge Clk); #1;
        // in-flight access must ignore bus changes after capture
        drive(u0, !wr, wr, ~a, ~d, wr, !ub, !lb);
        if (abort_after >= 0) begin
            repeat (abort_after) @(posedge Clk);
            #1 drive(u0, 1'b0, 1'b0, a, 16'h0000, 1'b1, 1'b1, 1'b1);
            repeat (4) begin
                @(negedge Clk);
                chk("abort_r_low", 32'(get_r(u0)), 32'd0);
            end
            return;
        end
        got = 0;
        lat = 0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge Clk);
            if (get_r(u0)) begin
                got = 1;
                lat = c;
            end
        end
        chk("r_latency", 32'(lat), 32'(lat_exp));
        if (!wr) rd = get_d(u0);
        @(negedge Clk);
        chk("r_held", 32'(get_r(u0)), 32'd1);
        @(posedge Clk); #1;
        drive(u0, 1'b0, 1'b0, a, 16'h0000, wr, 1'b1, 1'b1);
        @(negedge Clk);
        if (got) chk("r_until_sampled", 32'(get_r(u0)), 32'd1);
        @(posedge Clk); #1;
        drive(u0, 1'b0, 1'b0, a, 16'h0000, 1'b1, 1'b1, 1'b1);
        @(negedge Clk);
        chk("r_release", 32'(get_r(u0)), 32'd0);
        chk("data_release", 32'(get_d(u0)), 32'd0);
        if (wr && !u0 && a < 20'd256) begin
            if (ub && lb) begin
                mdl[int'(a)] = d;
            end else if (mdl.exists(int'(a))) begin
                base = mdl[int'(a)];
`ifdef MEM_BYTE_WE_EN
                if (ub) base[15:8] = d[15:8];
                if (lb) base[7:0]  = d[7:0];
`else
                base = d;
`endif
                mdl[int'(a)] = base;
            end
        end
    endtask

    typedef struct {
        bit          wr;
        logic [19:0] a;
        logic [15:0] d;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] rdv;
        logic [19:0] a;
        logic [15:0] d;
        bit          wr;
        int          ab;
        bit          got;

        tbl[0] = '{1'b1, 20'h00010, 16'hBEEF, 16'h0000};
        tbl[1] = '{1'b0, 20'h00010, 16'h0000, 16'hBEEF};
        tbl[2] = '{1'b1, 20'h00000, 16'hC0DE, 16'h0000};
        tbl[3] = '{1'b1, 20'h01000, 16'h7777, 16'h0000};
        tbl[4] = '{1'b0, 20'h01000, 16'h0000, 16'h0000};
        tbl[5] = '{1'b0, 20'h00000, 16'h0000, 16'hC0DE};
        tbl[6] = '{1'b1, 20'h00005, 16'hA5A5, 16'h0000};
        tbl[7] = '{1'b1, 20'h10005, 16'h9999, 16'h0000};
        tbl[8] = '{1'b0, 20'h00005, 16'h0000, 16'hA5A5};
        tbl[9] = '{1'b0, 20'hFFF05, 16'h0000, 16'h0000};

        // reset state
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("reset_r1", 32'(R1), 32'd0);
        chk("reset_r0", 32'(R0), 32'd0);
        chk("reset_data1", 32'(Data1), 32'd0);
        chk("reset_data0", 32'(Data0), 32'd0);
        Reset = 1'b1;

        // table-driven transactions
        for (int i = 0; i < 10; i++) begin
            txn(1'b0, tbl[i].wr, tbl[i].a, tbl[i].d, 1'b1, 1'b1, -1, rdv);
            if (!tbl[i].wr) chk($sformatf("tbl_read_%0d", i), 32'(rdv), 32'(tbl[i].exp));
        end

        // write aborted one cycle into WAIT leaves the word untouched
        txn(1'b0, 1'b1, 20'h00005, 16'h1234, 1'b1, 1'b1, 1, rdv);
        txn(1'b0, 1'b0, 20'h00005, 16'h0000, 1'b1, 1'b1, -1, rdv);
        chk("abort_keeps_word", 32'(rdv), 32'h0000A5A5);

        // both requests high: ignored
        @(posedge Clk); #1;
        drive(1'b0, 1'b1, 1'b1, 20'h00010, 16'h5A5A, 1'b1, 1'b1, 1'b1);
        repeat (5) begin
            @(negedge Clk);
            chk("both_high_no_r", 32'(R1), 32'd0);
        end
        @(posedge Clk); #1;
        drive(1'b0, 1'b0, 1'b0, 20'h0, 16'h0000, 1'b1, 1'b1, 1'b1);
        txn(1'b0, 1'b0, 20'h00010, 16'h0000, 1'b1, 1'b1, -1, rdv);
        chk("both_high_no_write", 32'(rdv), 32'h0000BEEF);

        // reset on the edge that would have entered ACK for a write
        @(posedge Clk); #1;
        drive(1'b0, 1'b0, 1'b1, 20'h00000, 16'hDEAD, 1'b1, 1'b1, 1'b1);
        @(posedge Clk);
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 20'h0, 16'h0000, 1'b1, 1'b1, 1'b1);
        @(negedge Clk);
        chk("rst_wait_r_low", 32'(R1), 32'd0);
        txn(1'b0, 1'b0, 20'h00000, 16'h0000, 1'b1, 1'b1, -1, rdv);
        chk("rst_wait_no_write", 32'(rdv), 32'h0000C0DE);

        // reset during ACK of a read
        @(posedge Clk); #1;
        drive(1'b0, 1'b1, 1'b0, 20'h00010, 16'h0000, 1'b0, 1'b1, 1'b1);
        got = 0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge Clk);
            if (R1) got = 1;
        end
        chk("rst_ack_reached", 32'(got), 32'd1);
        chk("rst_ack_data", 32'(Data1), 32'h0000BEEF);
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 20'h0, 16'h0000, 1'b1, 1'b1, 1'b1);
        @(negedge Clk);
        chk("rst_ack_r_low", 32'(R1), 32'd0);
        chk("rst_ack_data_z", 32'(Data1), 32'd0);

        // zero wait states
        txn(1'b1, 1'b1, 20'h00007, 16'h0042, 1'b1, 1'b1, -1, rdv);
        txn(1'b1, 1'b0, 20'h00007, 16'h0000, 1'b1, 1'b1, -1, rdv);
        chk("w0_read", 32'(rdv), 32'h00000042);
        txn(1'b1, 1'b0, 20'h01000, 16'h0000, 1'b1, 1'b1, -1, rdv);
        chk("w0_oor_read", 32'(rdv), 32'h00000000);

`ifdef MEM_BYTE_WE_EN
        txn(1'b0, 1'b1, 20'h00003, 16'hAAAA, 1'b1, 1'b1, -1, rdv);
        txn(1'b0, 1'b1, 20'h00003, 16'h5555, 1'b0, 1'b1, -1, rdv);
        txn(1'b0, 1'b0, 20'h00003, 16'h0000, 1'b1, 1'b1, -1, rdv);
        chk("be_lb_only", 32'(rdv), 32'h0000AA55);
        txn(1'b0, 1'b1, 20'h00003, 16'h1234, 1'b1, 1'b0, -1, rdv);
        txn(1'b0, 1'b1, 20'h00003, 16'hFFFF, 1'b0, 1'b0, -1, rdv);
        txn(1'b0, 1'b0, 20'h00003, 16'h0000, 1'b1, 1'b1, -1, rdv);
        chk("be_ub_then_none", 32'(rdv), 32'h00001255);
`endif

        // randomized traffic against the reference array
        for (int i = 0; i < 60; i++) begin
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 6) == 0)
                a = 20'($urandom_range(0, 15)) | (20'($urandom_range(1, 4095)) << 8);
            else
                a = 20'($urandom_range(0, 15));
            d  = 16'($urandom);
            ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 1)) : -1;
            txn(1'b0, wr, a, d, 1'b1, 1'b1, ab, rdv);
            if (!wr && ab < 0) begin
                if (a >= 20'd256)
                    chk("rand_oor_read", 32'(rdv), 32'd0);
                else if (mdl.exists(int'(a)))
                    chk($sformatf("rand_read_%0h", a), 32'(rdv), 32'(mdl[int'(a)]));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
